bin_to_trits: RTL

Sequential converter from an unsigned binary word to a vector of binary-coded trits (2 bits per trit: 00=0, 01=1, 10=2; 11 is never produced). It feeds the ternary min/max/any/consensus datapath: binary sources enter here and are encoded into the trit format those gates consume. It emits one trit per cycle, least significant first, by repeated division by 3. Both sides use valid/ready handshakes.

---
 rtl/ternary_pkg.sv | 16 +
 rtl/div3_comb.sv | 25 ++
 rtl/bin_to_trits.sv | 109 ++++++++++
 3 files changed

// File: rtl/ternary_pkg.sv
// Shared trit encodings and converter state for the ternary datapath.
// Trits are binary-coded in two bits; 2'b11 is never a legal value.
package ternary_pkg;

   localparam logic [1:0] TRIT_0   = 2'b00;
   localparam logic [1:0] TRIT_1   = 2'b01;
   localparam logic [1:0] TRIT_2   = 2'b10;
   localparam logic [1:0] TRIT_BAD = 2'b11;

   typedef enum logic [1:0] {
      IDLE,
      CONV,
      DONE
   } state_e;

endpackage

// File: rtl/div3_comb.sv
// Combinational divide-by-3: MSB-first restoring remainder chain.
// Remainder stays in {0,1,2}, so rem_o is always a legal trit.
module div3_comb #(
   parameter int WIDTH = 8
) (
   input  logic [WIDTH-1:0] q_i,
   output logic [WIDTH-1:0] quot_o,
   output logic [1:0]       rem_o
);

   always_comb begin
      logic [1:0] r;
      logic [2:0] s;
      r      = 2'd0;
      s      = 3'd0;
      quot_o = '0;
      for (int i = WIDTH - 1; i >= 0; i--) begin
         s         = {r, q_i[i]};
         quot_o[i] = (s >= 3'd3);
         r         = (s >= 3'd3) ? 2'(s - 3'd3) : s[1:0];
      end
      rem_o = r;
   end

endmodule

// File: rtl/bin_to_trits.sv
// Sequential binary-to-trit encoder, one trit per cycle, LS trit first.
// Valid/ready on both sides; results held until the out handshake.
module bin_to_trits
   import ternary_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int TRITS = 6
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [WIDTH-1:0]     in_data,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [2*TRITS-1:0]   out_trits,
   output logic                 out_ovf
);

   localparam int KW = (TRITS > 1) ? $clog2(TRITS) : 1;
   localparam logic [KW-1:0] K_LAST = KW'(TRITS - 1);

   generate
      if (TRITS < 1 || WIDTH < 2) begin : g_bad_params
         $error("bin_to_trits: need TRITS>=1 and WIDTH>=2");
      end
   endgenerate

   state_e             state_q, state_d;
   logic [WIDTH-1:0]   quo_q, quo_d;
   logic [KW-1:0]      k_q, k_d;
   logic [2*TRITS-1:0] trits_q, trits_d;
   logic               ovf_q, ovf_d;

   logic [WIDTH-1:0]   quot;
   logic [1:0]         rem;

   div3_comb #(
      .WIDTH (WIDTH)
   ) u_div3 (
      .q_i    (quo_q),
      .quot_o (quot),
      .rem_o  (rem)
   );

   always_comb begin
      state_d = state_q;
      quo_d   = quo_q;
      k_d     = k_q;
      trits_d = trits_q;
      ovf_d   = ovf_q;
      unique case (state_q)
         IDLE: begin
            if (in_valid) begin
               quo_d   = in_data;
               k_d     = '0;
               trits_d = '0;
               ovf_d   = 1'b0;
               state_d = CONV;
            end
         end
         CONV: begin
            quo_d = quot;
            k_d   = k_q + KW'(1);
            for (int i = 0; i < TRITS; i++) begin
               if (k_q == KW'(i)) begin
                  trits_d[2*i +: 2] = rem;
               end
            end
            // Leftover quotient after the last trit means the value did not fit.
            if (k_q == K_LAST) begin
               k_d     = '0;
               ovf_d   = |quot;
               state_d = DONE;
            end
         end
         DONE: begin
            if (out_ready) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         quo_q   <= '0;
         k_q     <= '0;
         trits_q <= '0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         quo_q   <= quo_d;
         k_q     <= k_d;
         trits_q <= trits_d;
         ovf_q   <= ovf_d;
      end
   end

   assign in_ready  = (state_q == IDLE);
   assign out_valid = (state_q == DONE);
   assign out_trits = trits_q;
   assign out_ovf   = ovf_q;

endmodule
